dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 16 +
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, lane offsets and
// the load right-align function.
package dmem_responder_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [1:0] LaneOff0 = 2'd0;
  localparam logic [1:0] LaneOff1 = 2'd1;
  localparam logic [1:0] LaneOff2 = 2'd2;
  localparam logic [1:0] LaneOff3 = 2'd3;

  // Shift the addressed byte/halfword down to bit 0, zero-filling from the top.
  function automatic logic [31:0] right_align(input logic [31:0] word, input logic [1:0] off);
    logic [31:0] res;
    res = word;
    unique case (off)
      LaneOff0: res = word;
      LaneOff1: res = {8'h00, word[31:8]};
      LaneOff2: res = {16'h0000, word[31:16]};
      LaneOff3: res = {24'h000000, word[31:24]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req;
  logic [31:0] addr;
  logic [3:0]  wea;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (output req, addr, wea, wdata, input ack, rdata, err, busy);
  modport slave  (input req, addr, wea, wdata, output ack, rdata, err, busy);

endinterface

// File: rtl/dmem_array.sv
// Word array with byte-enabled synchronous write and registered synchronous read; no reset,
// so it maps onto block RAM.
module dmem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] index,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYC wait states, byte-enabled writes and
// right-aligned reads with out-of-range detection.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned CntW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      wea_q;
  logic            accept, enter_resp;

  logic [31:0]     op_addr, op_wdata;
  logic [3:0]      op_wea;
  logic            op_oor, op_read;
  logic [3:0]      ram_we;
  logic            ram_re;
  logic [31:0]     ram_rdata;

  logic            rd_zero_q;
  logic [1:0]      rd_off_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          accept = 1'b1;
          if (WAIT_CYC == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wea_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.addr;
        wea_q   <= bus.wea;
        wdata_q <= bus.wdata;
      end
    end
  end

  // With no wait states the memory access happens on the accepting edge, so use live inputs.
  always_comb begin
    op_addr  = (state_q == StIdle) ? bus.addr  : addr_q;
    op_wea   = (state_q == StIdle) ? bus.wea   : wea_q;
    op_wdata = (state_q == StIdle) ? bus.wdata : wdata_q;
    op_oor   = |(op_addr >> (ADDR_W + 2));
    op_read  = (op_wea == 4'b0000);
    ram_we   = (enter_resp && !op_oor) ? op_wea : 4'b0000;
    ram_re   = enter_resp && !op_oor && op_read;
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .index (op_addr[ADDR_W+1:2]),
    .we    (ram_we),
    .wdata (op_wdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // The RAM output register holds the last in-range read; these qualify it for rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_zero_q <= 1'b1;
      rd_off_q  <= LaneOff0;
    end else if (enter_resp && op_read) begin
      rd_zero_q <= op_oor;
      rd_off_q  <= op_addr[1:0];
    end
  end

  assign bus.ack   = (state_q == StResp);
  assign bus.err   = (state_q == StResp) && (|(addr_q >> (ADDR_W + 2)));
  assign bus.busy  = (state_q != StIdle);
  assign bus.rdata = rd_zero_q ? 32'h0 : right_align(ram_rdata, rd_off_q);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned AddrW   = 10;
  localparam int unsigned WaitCyc = 3;
  localparam int unsigned Words   = 2 ** AddrW;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] model [Words];
  logic [31:0] last_rd;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W   (AddrW),
    .WAIT_CYC (WaitCyc)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    bus.req = 1'b1; bus.addr = a; bus.wea = w; bus.wdata = d;
    @(posedge clk);
    #1 bus.req = 1'b0;
    lat = 0; rd = 32'h0; e = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        lat = k; rd = bus.rdata; e = bus.err;
      end
    end
  endtask

  // Expected results come from the array model: byte lanes, shift-down reads, range check.
  task automatic op(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                    input string tag);
    logic [31:0] rd, exp_rd;
    logic        e, oor;
    int          lat, idx;
    oor = (a >> (AddrW + 2)) != 0;
    idx = int'(a[AddrW+1:2]);
    if (w == 4'b0000) exp_rd = oor ? 32'h0 : (model[idx] >> (8 * a[1:0]));
    else              exp_rd = last_rd;
    txn(a, w, d, rd, e, lat);
    chk({tag, ".latency"}, 32'(lat), 32'(WaitCyc + 1));
    chk({tag, ".err"}, {31'h0, e}, {31'h0, oor});
    chk({tag, ".rdata"}, rd, exp_rd);
    if (!oor) begin
      for (int i = 0; i < 4; i++) if (w[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    end
    last_rd = exp_rd;
    @(negedge clk);
    chk({tag, ".ack_one_cycle"}, {31'h0, bus.ack}, 32'h0);
  endtask

  initial begin
    int a0, a1, a2, n_ack, low, acks;
    logic [31:0] ra;
    logic [3:0]  rw;

    rst = 1'b1;
    bus.req = 1'b0; bus.addr = '0; bus.wea = '0; bus.wdata = '0;
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset.ack", {31'h0, bus.ack}, 32'h0);
    chk("reset.err", {31'h0, bus.err}, 32'h0);
    chk("reset.busy", {31'h0, bus.busy}, 32'h0);
    chk("reset.rdata", bus.rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) op(32'(4 * i), 4'hF, $urandom, "preload");

    op(32'h10, 4'hF, 32'hDEADBEEF, "word_write");
    op(32'h10, 4'h0, 32'h0, "word_read");
    chk("word_read.value", last_rd, 32'hDEADBEEF);

    op(32'h20, 4'hF, 32'h11223344, "lane_preload");
    op(32'h21, 4'b0010, 32'h0000AB00, "lane1_write");
    op(32'h20, 4'h0, 32'h0, "lane_read0");
    chk("lane_read0.value", last_rd, 32'h1122AB44);
    op(32'h21, 4'h0, 32'h0, "lane_read1");
    chk("lane_read1.value", last_rd, 32'h001122AB);

    op(32'h30, 4'hF, 32'hCAFE1234, "half_preload");
    op(32'h32, 4'h0, 32'h0, "half_read2");
    chk("half_read2.value", last_rd, 32'h0000CAFE);

    // Back-to-back reads with req held high.
    a0 = -100; a1 = -100; a2 = -100; n_ack = 0; low = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.addr = 32'h10; bus.wea = 4'h0;
    for (int k = 0; k < 40 && n_ack < 3; k++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        if (n_ack == 0) a0 = k; else if (n_ack == 1) a1 = k; else a2 = k;
        n_ack++;
        chk("b2b.rdata", bus.rdata, 32'hDEADBEEF);
        if (n_ack == 3) bus.req = 1'b0;
      end else if (n_ack >= 1 && bus.busy === 1'b0) begin
        low++;
      end
    end
    chk("b2b.period01", 32'(a1 - a0), 32'(WaitCyc + 2));
    chk("b2b.period12", 32'(a2 - a1), 32'(WaitCyc + 2));
    chk("b2b.busy_low", 32'(low), 32'd2);
    last_rd = 32'hDEADBEEF;
    @(negedge clk);

    op(32'h0000_1000, 4'hF, 32'h12345678, "oor_write");
    op(32'h0000_1000, 4'h0, 32'h0, "oor_read");
    chk("oor_read.value", last_rd, 32'h0);
    op(32'h0, 4'h0, 32'h0, "oor_word0_intact");

    // Reset in the middle of a write's wait states.
    @(negedge clk);
    bus.req = 1'b1; bus.addr = 32'h10; bus.wea = 4'hF; bus.wdata = 32'h55555555;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    chk("rstwait.busy_before", {31'h0, bus.busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rstwait.busy", {31'h0, bus.busy}, 32'h0);
    chk("rstwait.ack", {31'h0, bus.ack}, 32'h0);
    chk("rstwait.rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.ack !== 1'b0) acks++;
    end
    chk("rstwait.no_ack", 32'(acks), 32'h0);
    op(32'h10, 4'h0, 32'h0, "rstwait.readback");
    chk("rstwait.old_word", last_rd, 32'hDEADBEEF);

    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 9) == 0) ra = ($urandom_range(1, 20'hFFFFF) << 12) | $urandom_range(0, 255);
      else                           ra = 32'($urandom_range(0, 255));
      rw = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      op(ra, rw, $urandom, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
